prbs8_checker: RTL and testbench

- Serial receive-side checker for the 8-bit Fibonacci PRBS stream (polynomial x^8+x^6+x^5+x^4+1, feedback = s[7]^s[5]^s[4]^s[3], left shift with feedback into bit 0).
- Sits at the far end of a link or loopback. It self-synchronises to the incoming bit stream, then flywheels its own copy of the sequence.
- Flags bit errors, counts them, and declares loss of lock.

---
 rtl/prbs8_checker_if.sv | 25 ++
 rtl/prbs8_checker.sv | 136 +++++++++++++
 tb/tb_prbs8_checker.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs8_checker_if.sv
// rtl/prbs8_checker_if.sv - receive-bit stream and status bundle for prbs8_checker
// bit_count exists only when PRBS8_CHK_BITCNT_EN is defined.
interface prbs8_checker_if #(
   parameter int ERR_W = 16
);
   logic             in_valid;
   logic             in_bit;
   logic             clr_cnt;
   logic             locked;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;
`ifdef PRBS8_CHK_BITCNT_EN
   logic [31:0]      bit_count;

   modport master (output in_valid, in_bit, clr_cnt,
                   input  locked, err_pulse, err_count, bit_count);
   modport slave  (input  in_valid, in_bit, clr_cnt,
                   output locked, err_pulse, err_count, bit_count);
`else
   modport master (output in_valid, in_bit, clr_cnt,
                   input  locked, err_pulse, err_count);
   modport slave  (input  in_valid, in_bit, clr_cnt,
                   output locked, err_pulse, err_count);
`endif
endinterface

// File: rtl/prbs8_checker.sv
// rtl/prbs8_checker.sv - self-synchronising PRBS8 (x^8+x^6+x^5+x^4+1) bit-error checker
// Optional PRBS8_CHK_BITCNT_EN adds a saturating locked-bit counter for BER.
module prbs8_checker #(
   parameter int LOCK_CNT    = 16,
   parameter int WIN_LEN     = 64,
   parameter int LOSS_THRESH = 4,
   parameter int ERR_W       = 16
) (
   input  logic            clk,
   input  logic            rst,
   prbs8_checker_if.slave  bus
);
   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT);
   localparam logic [8:0] WIN_LAST  = 9'(WIN_LEN);
   localparam logic [8:0] LOSS_LAST = 9'(LOSS_THRESH);

   state_t           state;
   logic [7:0]       sh;
   logic [3:0]       fill_cnt;
   logic [7:0]       match_cnt;
   logic [8:0]       win_cnt;
   logic [8:0]       win_err;
   logic             locked_q;
   logic             pulse_q;
   logic [ERR_W-1:0] err_q;

   logic       pred;
   logic       mis;
   logic [7:0] sh_in;
   logic [7:0] sh_fly;

   assign pred   = sh[7] ^ sh[5] ^ sh[4] ^ sh[3];
   assign mis    = bus.in_valid & (bus.in_bit != pred);
   assign sh_in  = {sh[6:0], bus.in_bit};
   assign sh_fly = {sh[6:0], pred};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         sh        <= 8'h00;
         fill_cnt  <= 4'd0;
         match_cnt <= 8'd0;
         win_cnt   <= 9'd0;
         win_err   <= 9'd0;
         locked_q  <= 1'b0;
         pulse_q   <= 1'b0;
         err_q     <= '0;
      end else begin
         pulse_q <= 1'b0;
         if (bus.clr_cnt)
            err_q <= '0;
         if (bus.in_valid) begin
            case (state)
               HUNT: begin
                  sh <= sh_in;
                  if (fill_cnt != 4'd8)
                     fill_cnt <= fill_cnt + 4'd1;
                  // fill_cnt is about to be (or already is) 8
                  if (fill_cnt >= 4'd7 && sh_in != 8'h00) begin
                     state     <= VERIFY;
                     match_cnt <= 8'd0;
                  end
               end
               VERIFY: begin
                  sh <= sh_in;
                  if (mis) begin
                     state    <= HUNT;
                     fill_cnt <= 4'd0;
                  end else begin
                     match_cnt <= match_cnt + 8'd1;
                     if (match_cnt + 8'd1 == LOCK_LAST) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        win_cnt  <= 9'd0;
                        win_err  <= 9'd0;
                     end
                  end
               end
               LOCKED: begin
                  sh <= sh_fly;
                  if (mis) begin
                     pulse_q <= 1'b1;
                     if (bus.clr_cnt)
                        err_q <= {{(ERR_W-1){1'b0}}, 1'b1};
                     else if (err_q != {ERR_W{1'b1}})
                        err_q <= err_q + 1'b1;
                  end
                  // loss of lock wins over a window rollover on the same bit
                  if (mis && win_err + 9'd1 == LOSS_LAST) begin
                     state    <= HUNT;
                     locked_q <= 1'b0;
                     fill_cnt <= 4'd0;
                  end else if (win_cnt + 9'd1 == WIN_LAST) begin
                     win_cnt <= 9'd0;
                     win_err <= 9'd0;
                  end else begin
                     win_cnt <= win_cnt + 9'd1;
                     if (mis)
                        win_err <= win_err + 9'd1;
                  end
               end
               default: begin
                  state    <= HUNT;
                  locked_q <= 1'b0;
                  fill_cnt <= 4'd0;
               end
            endcase
         end
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = pulse_q;
   assign bus.err_count = err_q;

`ifdef PRBS8_CHK_BITCNT_EN
   logic [31:0] bit_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_q <= 32'd0;
      end else if (bus.in_valid && state == LOCKED) begin
         if (bus.clr_cnt)
            bit_q <= 32'd1;
         else if (bit_q != 32'hFFFF_FFFF)
            bit_q <= bit_q + 32'd1;
      end else if (bus.clr_cnt) begin
         bit_q <= 32'd0;
      end
   end

   assign bus.bit_count = bit_q;
`endif
endmodule

// File: tb/tb_prbs8_checker.sv
// tb/tb_prbs8_checker.sv - randomized self-checking bench for prbs8_checker
// Reference model works on the received-bit history recurrence b[n]=b[n-8]^b[n-6]^b[n-5]^b[n-4].
module tb_prbs8_checker;
   localparam int LOCK_CNT    = 16;
   localparam int WIN_LEN     = 64;
   localparam int LOSS_THRESH = 4;
   localparam int ERR_W       = 16;
   localparam longint ERR_MAX = (64'd1 << ERR_W) - 1;
   localparam longint BIT_MAX = 64'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prbs8_checker_if #(.ERR_W(ERR_W)) bus ();

   prbs8_checker #(
      .LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN),
      .LOSS_THRESH(LOSS_THRESH), .ERR_W(ERR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int     m_mode;          // 0 hunt, 1 verify, 2 locked
   int     m_hist[$];       // last 8 bits of the tracked sequence, newest last
   int     m_fill, m_match, m_win_pos, m_win_err;
   bit     m_pulse;
   longint m_errs, m_bits;

   function automatic void model_reset();
      m_mode = 0;
      m_hist.delete();
      for (int i = 0; i < 8; i++) m_hist.push_back(0);
      m_fill = 0; m_match = 0; m_win_pos = 0; m_win_err = 0;
      m_pulse = 0; m_errs = 0; m_bits = 0;
   endfunction

   function automatic void push_bit(int b);
      m_hist.push_back(b);
      void'(m_hist.pop_front());
   endfunction

   function automatic void model_step(bit v, bit b, bit c);
      int  n;
      int  pred;
      bit  mis;
      bit  counted;
      counted = v && (m_mode == 2);
      mis = 1'b0;
      m_pulse = 1'b0;
      if (v) begin
         n    = m_hist.size();
         pred = m_hist[n-8] ^ m_hist[n-6] ^ m_hist[n-5] ^ m_hist[n-4];
         mis  = (int'(b) != pred);
         case (m_mode)
            0: begin
               push_bit(int'(b));
               if (m_fill < 8) m_fill++;
               if (m_fill == 8 && m_hist.sum() != 0) begin
                  m_mode = 1; m_match = 0;
               end
            end
            1: begin
               push_bit(int'(b));
               if (mis) begin
                  m_mode = 0; m_fill = 0;
               end else begin
                  m_match++;
                  if (m_match == LOCK_CNT) begin
                     m_mode = 2; m_win_pos = 0; m_win_err = 0;
                  end
               end
            end
            default: begin
               push_bit(pred);
               m_win_pos++;
               if (mis) begin
                  m_pulse = 1'b1;
                  m_win_err++;
               end
               if (mis && m_win_err == LOSS_THRESH) begin
                  m_mode = 0; m_fill = 0;
               end else if (m_win_pos == WIN_LEN) begin
                  m_win_pos = 0; m_win_err = 0;
               end
            end
         endcase
      end
      if (c) m_errs = (counted && mis) ? 1 : 0;
      else if (counted && mis && m_errs < ERR_MAX) m_errs++;
      if (c) m_bits = counted ? 1 : 0;
      else if (counted && m_bits < BIT_MAX) m_bits++;
   endfunction

   // ---------------- stimulus helpers ----------------
   logic [7:0] g = 8'h01;

   function automatic bit gen_next();
      bit fb;
      fb = g[7] ^ g[5] ^ g[4] ^ g[3];
      g  = {g[6:0], fb};
      return fb;
   endfunction

   task automatic compare_outputs();
      check("locked",    64'(bus.locked),    64'(m_mode == 2));
      check("err_pulse", 64'(bus.err_pulse), 64'(m_pulse));
      check("err_count", 64'(bus.err_count), 64'(m_errs));
`ifdef PRBS8_CHK_BITCNT_EN
      check("bit_count", 64'(bus.bit_count), 64'(m_bits));
`endif
   endtask

   task automatic step(input bit v, input bit b, input bit c);
      @(negedge clk);
      bus.in_valid = v;
      bus.in_bit   = b;
      bus.clr_cnt  = c;
      @(posedge clk);
      model_step(v, b, c);
      #1;
      compare_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clr_cnt = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      compare_outputs();
      rst = 1'b0;
   endtask

   task automatic good_bits(input int n);
      for (int i = 0; i < n; i++) step(1'b1, gen_next(), 1'b0);
   endtask

   task automatic run_to_lock(input string tag, input bit gaps);
      int nvalid;
      bit v;
      nvalid = 0;
      for (int i = 0; i < 300 && !bus.locked; i++) begin
         v = gaps ? ((i % 2 == 0) || ($urandom_range(0, 3) == 0)) : 1'b1;
         if (v) begin
            nvalid++;
            step(1'b1, gen_next(), 1'b0);
         end else begin
            step(1'b0, 1'($urandom), 1'b0);
         end
      end
      check(tag, 64'(nvalid), 64'd24);
   endtask

   task automatic do_lock();
      do_reset();
      run_to_lock("lock_after_reset", 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pos[4];
      int k;
      bit bad;
      bit seen;
      bit v;

      bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clr_cnt = 1'b0;
      model_reset();
      do_reset();
      check("reset_locked", 64'(bus.locked), 64'd0);

      // error-free lock from generator seeded 8'h01, 1000 bits in total
      g = 8'h01;
      run_to_lock("first_lock_latency", 1'b0);
      good_bits(976);
      check("clean_err_count", 64'(bus.err_count), 64'd0);
      check("clean_locked", 64'(bus.locked), 64'd1);

      // single error does not corrupt the flywheel
      do_lock();
      good_bits(30);
      step(1'b1, ~gen_next(), 1'b0);
      check("single_pulse", 64'(bus.err_pulse), 64'd1);
      check("single_count", 64'(bus.err_count), 64'd1);
      good_bits(1);
      check("single_pulse_end", 64'(bus.err_pulse), 64'd0);
      good_bits(200);
      check("single_count_after", 64'(bus.err_count), 64'd1);
      check("single_locked", 64'(bus.locked), 64'd1);

      // four errors within one window force loss of lock, then re-lock
      do_lock();
      pos[0] = $urandom_range(0, 10);
      for (int j = 1; j < 4; j++) pos[j] = pos[j-1] + 1 + $urandom_range(0, 12);
      k = 0;
      for (int i = 0; i <= pos[3]; i++) begin
         bad = (k < 4) && (i == pos[k]);
         if (bad) k++;
         step(1'b1, gen_next() ^ bad, 1'b0);
      end
      check("loss_locked", 64'(bus.locked), 64'd0);
      check("loss_count", 64'(bus.err_count), 64'd4);
      run_to_lock("relock_latency", 1'b0);

      // three errors per window across a rollover keep lock
      do_lock();
      for (int i = 0; i < 130; i++) begin
         bad = (i == 5) || (i == 20) || (i == 40) || (i == 70) || (i == 90) || (i == 110);
         step(1'b1, gen_next() ^ bad, 1'b0);
      end
      check("rollover_locked", 64'(bus.locked), 64'd1);
      check("rollover_count", 64'(bus.err_count), 64'd6);

      // all-zero stream never locks
      do_reset();
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (bus.locked) seen = 1'b1;
      end
      check("zero_never_locks", 64'(seen), 64'd0);

      // gaps in in_valid do not change lock latency in valid bits
      do_reset();
      run_to_lock("gap_lock_latency", 1'b1);

      // clr_cnt alone and together with a counted error
      do_lock();
      good_bits(10);
      step(1'b1, ~gen_next(), 1'b0);
      step(1'b1, ~gen_next(), 1'b1);
      check("clr_with_err", 64'(bus.err_count), 64'd1);
      step(1'b0, 1'b0, 1'b1);
      check("clr_alone", 64'(bus.err_count), 64'd0);
      check("clr_keeps_lock", 64'(bus.locked), 64'd1);

      // reset while locked with a nonzero count
      step(1'b1, ~gen_next(), 1'b0);
      do_reset();
      check("rst_locked", 64'(bus.locked), 64'd0);
      check("rst_count", 64'(bus.err_count), 64'd0);

`ifdef PRBS8_CHK_BITCNT_EN
      do_lock();
      good_bits(100);
      check("bit_count_100", 64'(bus.bit_count), 64'd100);
`endif

      // randomized traffic: gaps, sparse errors, clears, occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
         end else begin
            v = ($urandom_range(0, 3) != 0);
            if (v)
               step(1'b1, gen_next() ^ ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 99) == 0));
            else
               step(1'b0, 1'($urandom), ($urandom_range(0, 99) == 0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
